// File: rtl/eprisc_uart_transmitter_if.sv
// eprisc_uart_transmitter_if: register-side bus of the TTL serial transmitter
// master: controller side (drives iTxData/iTxWrite/iTxClearOverrun, observes status and line)
// slave: transmitter side (observes write/clear, drives oTxFull/oTxEmpty/oTxBusy/oTxOverrun/oTTLSerialTX)
interface eprisc_uart_transmitter_if;
  logic [7:0] iTxData;
  logic       iTxWrite;
  logic       iTxClearOverrun;
  logic       oTxFull;
  logic       oTxEmpty;
  logic       oTxBusy;
  logic       oTxOverrun;
  logic       oTTLSerialTX;
  modport master (
    output iTxData, iTxWrite, iTxClearOverrun,
    input  oTxFull, oTxEmpty, oTxBusy, oTxOverrun, oTTLSerialTX
  );
  modport slave (
    input  iTxData, iTxWrite, iTxClearOverrun,
    output oTxFull, oTxEmpty, oTxBusy, oTxOverrun, oTTLSerialTX
  );
endinterface

// File: rtl/eprisc_uart_transmitter.sv
// eprisc_uart_transmitter: FIFO-buffered 8N1 TTL serial transmitter (8E1 with UART_TX_PARITY_EN)
// iBoardClock/iBoardReset: board clock, async active-high reset
// bus (slave): iTxData/iTxWrite enqueue, iTxClearOverrun, status flags, oTTLSerialTX line
module eprisc_uart_transmitter #(
  parameter int pClockDivide   = 256,
  parameter int pFifoDepthLog2 = 2
) (
  input logic iBoardClock,
  input logic iBoardReset,
  eprisc_uart_transmitter_if.slave bus
);
  localparam int          D   = 1 << pFifoDepthLog2;
  localparam int          CW  = pFifoDepthLog2 + 1;
  localparam logic [15:0] DIV = 16'(pClockDivide - 1);
`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  logic parity;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
  state_t state;
  logic [7:0] mem [D];
  logic [pFifoDepthLog2-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_next;
  logic [15:0] cnt;
  logic [2:0] idx;
  logic [7:0] shift;
  logic full, empty, overrun, busy, tx, push, pop, last;
  assign last = cnt == 16'd0;
  assign push = bus.iTxWrite && !full;
  // pop from IDLE, or on the final stop cycle so frames run back-to-back
  assign pop = !empty && (state == IDLE || (state == STOP && last));
  always_comb count_next = count + CW'(push) - CW'(pop);
  assign bus.oTxFull      = full;
  assign bus.oTxEmpty     = empty;
  assign bus.oTxBusy      = busy;
  assign bus.oTxOverrun   = overrun;
  assign bus.oTTLSerialTX = tx;
  always_ff @(posedge iBoardClock)
    if (push) mem[wr_ptr] <= bus.iTxData;
  always_ff @(posedge iBoardClock or posedge iBoardReset)
    if (iBoardReset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      full    <= 1'b0;
      empty   <= 1'b1;
      overrun <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count   <= count_next;
      full    <= count_next == CW'(D);
      empty   <= count_next == '0;
      overrun <= (bus.iTxWrite && full) ? 1'b1 : bus.iTxClearOverrun ? 1'b0 : overrun;
    end
  always_ff @(posedge iBoardClock or posedge iBoardReset)
    if (iBoardReset) begin
      state <= IDLE;
      tx    <= 1'b1;
      busy  <= 1'b0;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
`ifdef UART_TX_PARITY_EN
      parity <= 1'b0;
`endif
    end else if (pop) begin
      state <= START;
      tx    <= 1'b0;
      busy  <= 1'b1;
      cnt   <= DIV;
      shift <= mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
      parity <= ^mem[rd_ptr];
`endif
    end else begin
      case (state)
        START:
          if (last) begin
            state <= DATA;
            cnt   <= DIV;
            idx   <= '0;
            tx    <= shift[0];
          end else cnt <= cnt - 16'd1;
        DATA:
          if (last) begin
            cnt <= DIV;
            if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
              tx    <= parity;
`else
              state <= STOP;
              tx    <= 1'b1;
`endif
            end else begin
              idx   <= idx + 3'd1;
              shift <= shift >> 1;
              tx    <= shift[1];
            end
          end else cnt <= cnt - 16'd1;
`ifdef UART_TX_PARITY_EN
        PARITY:
          if (last) begin
            state <= STOP;
            cnt   <= DIV;
            tx    <= 1'b1;
          end else cnt <= cnt - 16'd1;
`endif
        STOP:
          if (last) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else cnt <= cnt - 16'd1;
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
endmodule

// File: tb/tb_eprisc_uart_transmitter.sv
// tb_eprisc_uart_transmitter: queue-model bench for the TTL serial transmitter
module tb_eprisc_uart_transmitter;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int BIT = 256;
  localparam int FRAME = NB * BIT;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  int busy_cycles = 0;
  eprisc_uart_transmitter_if bus();
  eprisc_uart_transmitter #(.pClockDivide(BIT), .pFifoDepthLog2(2)) dut (
    .iBoardClock(clk),
    .iBoardReset(rst),
    .bus(bus)
  );
  always #2 clk = ~clk;

  task automatic check(input string n, input logic [31:0] a, input logic [31:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  // line waveform model: one queue entry per clock of the frame in flight
  logic [7:0] mq[$];
  bit bq[$];
  bit m_ov = 1'b0;
  always @(posedge clk or posedge rst) begin
    bit wasfull;
    logic [10:0] f;
    logic [7:0] b;
    if (rst) begin
      mq.delete();
      bq.delete();
      m_ov = 1'b0;
    end else begin
      wasfull = mq.size() == 4;
      if (bq.size() > 0) void'(bq.pop_front());
      if (bq.size() == 0 && mq.size() > 0) begin
        b = mq.pop_front();
`ifdef UART_TX_PARITY_EN
        f = {1'b1, ^b, b, 1'b0};
`else
        f = {1'b0, 1'b1, b, 1'b0};
`endif
        for (int i = 0; i < NB; i++)
          for (int j = 0; j < BIT; j++) bq.push_back(f[i]);
      end
      if (bus.iTxWrite && wasfull) m_ov = 1'b1;
      else if (bus.iTxClearOverrun) m_ov = 1'b0;
      if (bus.iTxWrite && !wasfull) mq.push_back(bus.iTxData);
    end
  end

  always @(negedge clk) begin
    check("line", bus.oTTLSerialTX, bq.size() > 0 ? bq[0] : 1'b1);
    check("busy", bus.oTxBusy, bq.size() != 0);
    check("empty", bus.oTxEmpty, mq.size() == 0);
    check("full", bus.oTxFull, mq.size() == 4);
    check("overrun", bus.oTxOverrun, m_ov);
    if (bus.oTxBusy === 1'b1) busy_cycles++;
  end

  task automatic write_byte(input logic [7:0] d);
    @(negedge clk);
    bus.iTxData  = d;
    bus.iTxWrite = 1'b1;
    @(negedge clk);
    bus.iTxWrite = 1'b0;
  endtask

  task automatic sample_frame(input string n, input logic [10:0] e, input int nb);
    bit seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      seen = bus.oTTLSerialTX === 1'b0;
    end
    check({n, "_start_seen"}, seen, 1'b1);
    repeat (BIT / 2 - 1) @(negedge clk);
    for (int i = 0; i < nb; i++) begin
      if (i > 0) repeat (BIT) @(negedge clk);
      check($sformatf("%s_bit%0d", n, i), bus.oTTLSerialTX, e[i]);
    end
  endtask

  task automatic wait_idle(input int maxc);
    bit done = 1'b0;
    for (int i = 0; i < maxc && !done; i++) begin
      @(negedge clk);
      done = bus.oTxBusy === 1'b0 && bus.oTxEmpty === 1'b1;
    end
    check("idle_reached", done, 1'b1);
  endtask

  initial begin
    int b0;
    bus.iTxData = 8'h00;
    bus.iTxWrite = 1'b0;
    bus.iTxClearOverrun = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_line", bus.oTTLSerialTX, 1'b1);
    check("rst_empty", bus.oTxEmpty, 1'b1);
    check("rst_full", bus.oTxFull, 1'b0);
    check("rst_busy", bus.oTxBusy, 1'b0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    b0 = busy_cycles;
    write_byte(8'h31);
`ifdef UART_TX_PARITY_EN
    sample_frame("f31", 11'b11001100010, 11);
`else
    sample_frame("f31", 11'b01001100010, 10);
`endif
    wait_idle(FRAME);
    check("busy_one_frame", busy_cycles - b0, FRAME);

`ifdef UART_TX_PARITY_EN
    repeat (10) @(negedge clk);
    b0 = busy_cycles;
    write_byte(8'h03);
    sample_frame("f03", 11'b10000000110, 11);
    wait_idle(FRAME);
    check("busy_frame03", busy_cycles - b0, 2816);
`endif

    repeat (10) @(negedge clk);
    b0 = busy_cycles;
    @(negedge clk);
    bus.iTxWrite = 1'b1;
    bus.iTxData = 8'h31;
    @(negedge clk);
    bus.iTxData = 8'h0E;
    @(negedge clk);
    bus.iTxData = 8'h41;
    @(negedge clk);
    bus.iTxWrite = 1'b0;
    wait_idle(4 * FRAME);
    check("busy_three_frames", busy_cycles - b0, 3 * FRAME);

    repeat (10) @(negedge clk);
    b0 = busy_cycles;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.iTxWrite = 1'b1;
      bus.iTxData = 8'(8'h10 + i);
    end
    @(negedge clk);
    bus.iTxWrite = 1'b0;
    check("six_full", bus.oTxFull, 1'b1);
    check("six_overrun", bus.oTxOverrun, 1'b1);
    wait_idle(6 * FRAME);
    check("busy_five_frames", busy_cycles - b0, 5 * FRAME);
    check("overrun_sticky", bus.oTxOverrun, 1'b1);
    @(negedge clk);
    bus.iTxClearOverrun = 1'b1;
    @(negedge clk);
    bus.iTxClearOverrun = 1'b0;
    check("overrun_cleared", bus.oTxOverrun, 1'b0);

    repeat (10) @(negedge clk);
    write_byte(8'hA5);
    write_byte(8'h5A);
    repeat (5 * BIT + 100) @(negedge clk);
    check("midframe_busy", bus.oTxBusy, 1'b1);
    #1 rst = 1'b1;
    #1;
    check("async_line", bus.oTTLSerialTX, 1'b1);
    check("async_empty", bus.oTxEmpty, 1'b1);
    check("async_busy", bus.oTxBusy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    b0 = busy_cycles;
    repeat (3000) @(negedge clk);
    check("no_residual_frame", busy_cycles - b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/eprisc_uart_transmitter.md
# eprisc_uart_transmitter

TTL serial transmitter for the epRISC I/O controller: the outbound counterpart of the existing TTL serial receiver, driving `oTTLSerialTX`. It accepts bytes from the controller's register interface into a small FIFO and shifts them out as asynchronous 8N1 frames, LSB first, at a fixed divisor of the board clock. The default divisor gives a 256-clock bit period, which matches the receiver's line rate.

## Interface
Parameters:
- `pClockDivide`, default 256: board clocks per serial bit; legal range 2..65535.
- `pFifoDepthLog2`, default 2: log2 of the FIFO depth (4 entries).

Ports:
- `iBoardClock` in 1: board clock; everything is clocked on its rising edge.
- `iBoardReset` in 1: reset, asynchronous and active-high.
- `iTxData` in 8: byte to enqueue.
- `iTxWrite` in 1: enqueue strobe; one byte is taken per cycle when high.
- `oTxFull` in 1 → out 1: FIFO holds `2**pFifoDepthLog2` entries.
- `oTxEmpty` out 1: FIFO holds 0 entries.
- `oTxBusy` out 1: high whenever the FSM is not IDLE.
- `oTxOverrun` out 1: sticky flag, set when a write is dropped.
- `iTxClearOverrun` in 1: synchronous clear of `oTxOverrun`.
- `oTTLSerialTX` out 1: serial line; idle state is high.

## Operation
Reset values:
- `oTTLSerialTX`=1, `oTxEmpty`=1, `oTxFull`=0, `oTxBusy`=0, `oTxOverrun`=0.
- FIFO pointers and count are 0; the FSM is in IDLE; the bit counter is 0.

FIFO:
- Circular buffer with a (`pFifoDepthLog2`+1)-bit count. Pointers wrap modulo the depth.
- A write is accepted iff `iTxWrite`=1 and registered `oTxFull`=0. A write while full is dropped and sets `oTxOverrun`, even if a pop happens in the same cycle.
- A simultaneous push and pop on a non-full, non-empty FIFO leaves the count unchanged.
- `oTxFull` and `oTxEmpty` are registered from the next-state count.
- If set and clear of `oTxOverrun` coincide, set wins.

FSM states: IDLE, START, DATA, PARITY (present only with the macro), STOP.
- IDLE: line is 1. If the FIFO is non-empty, pop the head into the shift register and go to START.
- START: line is 0 for `pClockDivide` cycles.
- DATA: output `shift[0]`, shift right each bit, 8 bits, counted by a 3-bit index.
- STOP: line is 1 for `pClockDivide` cycles. At the last cycle of STOP:
  - if the FIFO is non-empty, pop and go directly to START, with no idle gap between frames;
  - otherwise go to IDLE.
- `oTTLSerialTX` is driven from a register; it is never combinational.

Reset asserted mid-frame: the line goes to 1 immediately and asynchronously, the frame is aborted, and the FIFO is flushed.

## Timing
- Bit counter runs from `pClockDivide`-1 down to 0. Each bit is exactly `pClockDivide` cycles; there is no rounding drift.
- Latency: byte written at rising edge k into an empty FIFO with the FSM in IDLE:
  - `oTxEmpty`=0 after edge k;
  - the pop and the START transition happen at edge k+1;
  - `oTTLSerialTX`=0 from edge k+1;
  - `oTxEmpty` returns to 1 after edge k+1 if no other write occurred.
- Frame length: 10×`pClockDivide` cycles (2560 at default); 11× with parity.
- `oTxBusy` rises at edge k+1 and falls at the edge that returns to IDLE.
- Back-to-back: the next start bit begins on the cycle after the last stop-bit cycle.
- With the line held at 256 clocks/bit and a 4-unit clock period, the bit time is 1024 time units.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - the PARITY state is inserted between DATA and STOP;
  - it transmits the even-parity bit (XOR of the 8 data bits) for one bit period;
  - frame is 11 bits.
- Not defined: no PARITY state and no parity logic; frame is 8N1, 10 bits.

## Test plan
- Reset, then write 0x31 once. Required line sequence, each bit lasting 256 cycles:
  - 0 (start), then 1,0,0,0,1,1,0,0, then 1 (stop);
  - idle afterwards;
  - `oTxBusy` high for exactly 2560 cycles.
- Write 0x31, 0x0E, 0x41 on consecutive cycles → three contiguous frames with no gaps:
  - total busy time 7680 cycles;
  - `oTxEmpty`=1 after the third pop.
- Write 6 bytes back-to-back with the FSM idle:
  - the first pops at k+1 and the next 4 fill the FIFO, so `oTxFull`=1;
  - the 6th is dropped and `oTxOverrun`=1;
  - exactly 5 frames are transmitted;
  - pulsing `iTxClearOverrun` clears the flag.
- Assert `iBoardReset` during bit 4 of a frame:
  - `oTTLSerialTX`=1 within the same time step;
  - FIFO empty, `oTxBusy`=0;
  - after release, no residual frame is sent.
- With `UART_TX_PARITY_EN`, write 0x31 (three ones):
  - parity bit = 1 after bit 7;
  - frame is 2816 cycles.
- With `UART_TX_PARITY_EN`, write 0x03: parity bit = 0.
